mem_arb_4m1s: RTL and testbench
===============================

MEM_ARB_4M1S -- requirements
Module: mem_arb_4m1s

Interface
REQ-001 SHALL have parameter RD_DEPTH, default 4, meaning max outstanding reads tracked (power of 2, 2..16).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports m0, m1, m2, m3, MemSplit32.Slave, bundle, requester ports.
REQ-005 SHALL have port s, MemSplit32.Master, bundle, shared memory port.
REQ-006 Each bundle SHALL carry the following signals. req, 1: request. we, 1: write enable. addr, 32: address. be, 4: byte enables. wdata, 32: write data. ack, 1: request accepted. resp, 1: read data valid. rdata, 32: read data.
REQ-007 SHALL have port rd_outstanding_o, output, $clog2(RD_DEPTH+1), count of accepted reads not yet responded.
REQ-008 SHALL have port spurious_resp_o, output, 1, registered one-cycle pulse, set when s.resp arrives with no read outstanding.

Function
REQ-009 Grant SHALL be combinational within the cycle.
REQ-010 Eligible master: mN.req=1, and (mN.we=1 or read FIFO not full).
REQ-011 Winner SHALL be the first eligible index scanning rr_ptr, rr_ptr+1, ... mod 4.
REQ-012 Winner's req/we/addr/be/wdata SHALL drive s; winner's ack SHALL equal s.ack.
REQ-013 Non-winners SHALL see ack=0.
REQ-014 With no eligible master, s.req, s.we, s.addr, s.be and s.wdata SHALL be 0.
REQ-015 rr_ptr SHALL update to (winner+1) mod 4 only on an accepted transfer (s.req & s.ack); otherwise it holds.
REQ-016 The winner SHALL not change while s.req=1 and s.ack=0 and the winner keeps req high.
REQ-016 mechanism: grant is held via a registered lock of the winner index.
REQ-017 Accepted read (s.req & s.ack & !s.we) SHALL push the 2-bit winner index into an in-order owner FIFO of RD_DEPTH entries.
REQ-018 Accepted writes SHALL push nothing and expect no resp.
REQ-019 On s.resp=1 with FIFO non-empty, the head owner SHALL get resp=1 and rdata=s.rdata in the same cycle, and the FIFO SHALL pop.
REQ-020 All other masters SHALL see resp=0 and rdata=0.
REQ-021 On s.resp=1 with FIFO empty, no master SHALL see resp, the FIFO SHALL be unchanged, and spurious_resp_o=1 next cycle.
REQ-022 Push and pop in the same cycle SHALL leave the count unchanged and keep order.
REQ-022 exception: push is impossible when full (REQ-010), even if a pop occurs that cycle.
REQ-023 rd_outstanding_o SHALL equal the FIFO occupancy, registered.
REQ-024 FIFO pointers SHALL wrap mod RD_DEPTH.
REQ-025 Writes SHALL proceed while reads are outstanding; read and write may interleave without ordering stalls.

Reset
REQ-026 While rst_i=1 at a rising edge, the following SHALL clear: rr_ptr=0, grant lock cleared, FIFO empty, rd_outstanding_o=0, spurious_resp_o=0.
REQ-027 Reset mid-operation SHALL discard outstanding-read ownership.
REQ-028 A resp arriving after reset SHALL be treated as spurious per REQ-021.
REQ-029 During reset, combinational outputs SHALL still follow REQ-009..014 using reset state.

Verification
REQ-030 Round-robin test.
- Stimulus: all four masters write continuously with s.ack=1.
- Required response: grants in order m0, m1, m2, m3, m0; each master gets exactly 1 ack per 4 cycles.
REQ-031 Pipelined read test.
- Stimulus: m2 reads 0x100, then m0 reads 0x200, both accepted; s.resp returns 0xAAAA then 0xBBBB.
- Required response: m2 gets 0xAAAA, then m0 gets 0xBBBB; rd_outstanding_o goes 1, 2, 1, 0.
REQ-032 Full-FIFO test.
- Stimulus: RD_DEPTH=4, 4 reads accepted and none responded; m1 then requests a read and m3 requests a write.
- Required response: m3 granted; m1.ack=0 until one resp pops; m1 accepted on the next cycle.
REQ-033 Spurious response test.
- Stimulus: s.resp=1 after reset with no reads.
- Required response: all mN.resp=0; spurious_resp_o=1 for exactly one cycle.
REQ-034 Hold/reset test.
- Stimulus: s.ack=0 for 3 cycles while m1 is requesting and m0 raises req.
- Required response: s stays driven by m1 until ack.
- Stimulus: rst_i asserted with 2 reads outstanding.
- Required response: rd_outstanding_o=0 the next cycle.

Source files
------------

// File: rtl/mem_arb_4m1s_if.sv
// MemSplit32 -- split-transaction 32-bit memory bundle.
// The request side (req/we/addr/be/wdata) is qualified by ack. The response
// side (resp/rdata) returns read data in order, one beat per accepted read.
// Modports:
//   Master : drives the request signals and receives ack/resp/rdata.
//   Slave  : receives the request signals and drives ack/resp/rdata.
interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport Slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/mem_arb_4m1s.sv
// mem_arb_4m1s -- four-requester round-robin arbiter onto one split-transaction
// memory port. Read ownership is remembered in an in-order FIFO so that each
// read response is steered back to the master that issued the read.
// Ports:
//   clk_i            : clock, all state changes on the rising edge
//   rst_i            : synchronous active-high reset
//   m0..m3           : requester bundles (MemSplit32.Slave)
//   s                : shared memory bundle (MemSplit32.Master)
//   rd_outstanding_o : number of accepted reads still waiting for a response
//   spurious_resp_o  : one-cycle pulse after a response arrived with no read pending
module mem_arb_4m1s #(
  parameter int RD_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  MemSplit32.Slave                        m0,
  MemSplit32.Slave                        m1,
  MemSplit32.Slave                        m2,
  MemSplit32.Slave                        m3,
  MemSplit32.Master                       s,
  output logic [$clog2(RD_DEPTH+1)-1:0]   rd_outstanding_o,
  output logic                            spurious_resp_o
);

  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam int PW = $clog2(RD_DEPTH);

  logic [3:0]    req_v;
  logic [3:0]    we_v;
  logic [31:0]   addr_v  [4];
  logic [3:0]    be_v    [4];
  logic [31:0]   wdata_v [4];
  logic [3:0]    ack_v;
  logic [3:0]    resp_v;
  logic [31:0]   rdata_v [4];
  logic [3:0]    elig;

  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic          lock_valid_q, lock_valid_d;
  logic [1:0]    lock_idx_q, lock_idx_d;
  logic [1:0]    owner_q [RD_DEPTH];
  logic [1:0]    owner_d [RD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          spurious_q, spurious_d;

  logic          win_valid;
  logic [1:0]    win_idx;
  logic [1:0]    scan_idx;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          rd_push;
  logic          rd_pop;
  logic [1:0]    head_idx;

  assign req_v   = {m3.req, m2.req, m1.req, m0.req};
  assign we_v    = {m3.we,  m2.we,  m1.we,  m0.we};
  assign addr_v  = '{m0.addr,  m1.addr,  m2.addr,  m3.addr};
  assign be_v    = '{m0.be,    m1.be,    m2.be,    m3.be};
  assign wdata_v = '{m0.wdata, m1.wdata, m2.wdata, m3.wdata};

  assign fifo_full  = (count_q == CW'(RD_DEPTH));
  assign fifo_empty = (count_q == '0);

  // A read is only eligible if its owner can be recorded this cycle.
  assign elig = req_v & (we_v | {4{~fifo_full}});

  // The locked master keeps the grant while it is still eligible, so a
  // stalled transfer cannot be overtaken; otherwise scan from rr_ptr.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    if (lock_valid_q && elig[lock_idx_q]) begin
      win_valid = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = rr_ptr_q + 2'(k);
        if (!win_valid && elig[scan_idx]) begin
          win_valid = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  assign s.req   = win_valid;
  assign s.we    = win_valid & we_v[win_idx];
  assign s.addr  = win_valid ? addr_v[win_idx]  : '0;
  assign s.be    = win_valid ? be_v[win_idx]    : '0;
  assign s.wdata = win_valid ? wdata_v[win_idx] : '0;

  assign accept   = win_valid & s.ack;
  assign rd_push  = accept & ~we_v[win_idx];
  assign rd_pop   = s.resp & ~fifo_empty;
  assign head_idx = owner_q[rd_ptr_q];

  // Per-master ack and response steering.
  always_comb begin
    ack_v  = '0;
    resp_v = '0;
    for (int i = 0; i < 4; i++) begin
      rdata_v[i] = '0;
      if (accept && (win_idx == 2'(i))) ack_v[i] = 1'b1;
      if (rd_pop && (head_idx == 2'(i))) begin
        resp_v[i]  = 1'b1;
        rdata_v[i] = s.rdata;
      end
    end
  end

  assign m0.ack = ack_v[0];  assign m0.resp = resp_v[0];  assign m0.rdata = rdata_v[0];
  assign m1.ack = ack_v[1];  assign m1.resp = resp_v[1];  assign m1.rdata = rdata_v[1];
  assign m2.ack = ack_v[2];  assign m2.resp = resp_v[2];  assign m2.rdata = rdata_v[2];
  assign m3.ack = ack_v[3];  assign m3.resp = resp_v[3];  assign m3.rdata = rdata_v[3];

  // Next-state: rotation pointer, grant lock, owner FIFO and spurious flag.
  always_comb begin
    rr_ptr_d     = accept ? (win_idx + 2'd1) : rr_ptr_q;
    lock_valid_d = win_valid & ~s.ack;
    lock_idx_d   = win_idx;
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (rd_push) begin
      owner_d[wr_ptr_q] = win_idx;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (rd_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d    = count_q + CW'(rd_push) - CW'(rd_pop);
    spurious_d = s.resp & fifo_empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      for (int i = 0; i < RD_DEPTH; i++) owner_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      spurious_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      spurious_q   <= spurious_d;
    end
  end

  assign rd_outstanding_o = count_q;
  assign spurious_resp_o  = spurious_q;

endmodule

// File: tb/tb_mem_arb_4m1s.sv
// tb_mem_arb_4m1s -- directed bench for mem_arb_4m1s: round-robin order,
// pipelined read steering, full owner FIFO, spurious responses, grant hold
// and reset of outstanding reads.
module tb_mem_arb_4m1s;
  localparam int RD_DEPTH = 4;
  localparam int CW = $clog2(RD_DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [CW-1:0] rd_outstanding_o;
  logic          spurious_resp_o;
  int            compared = 0;
  int            mismatched = 0;

  MemSplit32 m0_if ();
  MemSplit32 m1_if ();
  MemSplit32 m2_if ();
  MemSplit32 m3_if ();
  MemSplit32 s_if ();

  logic [3:0] ack_vec;
  logic [3:0] resp_vec;
  assign ack_vec  = {m3_if.ack,  m2_if.ack,  m1_if.ack,  m0_if.ack};
  assign resp_vec = {m3_if.resp, m2_if.resp, m1_if.resp, m0_if.resp};

  always #5 clk_i = ~clk_i;

  mem_arb_4m1s #(.RD_DEPTH(RD_DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .m0               (m0_if),
    .m1               (m1_if),
    .m2               (m2_if),
    .m3               (m3_if),
    .s                (s_if),
    .rd_outstanding_o (rd_outstanding_o),
    .spurious_resp_o  (spurious_resp_o)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic set_master(input int idx, input logic req, input logic we, input logic [31:0] addr);
    case (idx)
      0: begin m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.be = 4'hF; m0_if.wdata = ~addr; end
      1: begin m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.be = 4'hF; m1_if.wdata = ~addr; end
      2: begin m2_if.req = req; m2_if.we = we; m2_if.addr = addr; m2_if.be = 4'hF; m2_if.wdata = ~addr; end
      default: begin m3_if.req = req; m3_if.we = we; m3_if.addr = addr; m3_if.be = 4'hF; m3_if.wdata = ~addr; end
    endcase
  endtask

  // Advance past the next rising edge; inputs are changed here and outputs
  // are sampled one time unit later, well away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [3:0] exp_v;
    int         ack_cnt [4];
    int         owners [4];

    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) set_master(i, 1'b0, 1'b0, 32'h0);
    s_if.ack = 1'b0; s_if.resp = 1'b0; s_if.rdata = 32'h0;
    tick(); tick();
    rst_i = 1'b0;
    settle();
    check_output("reset_rd_outstanding", 32'(rd_outstanding_o), 32'd0);
    check_output("reset_spurious", 32'(spurious_resp_o), 32'd0);
    check_output("reset_s_req", 32'(s_if.req), 32'd0);
    check_output("reset_s_addr", s_if.addr, 32'h0);

    // Spurious response straight after reset.
    tick();
    s_if.resp = 1'b1; s_if.rdata = 32'h1234;
    settle();
    check_output("spur_no_resp", 32'(resp_vec), 32'd0);
    check_output("spur_no_rdata", m0_if.rdata | m1_if.rdata | m2_if.rdata | m3_if.rdata, 32'h0);
    tick();
    s_if.resp = 1'b0;
    settle();
    check_output("spur_pulse", 32'(spurious_resp_o), 32'd1);
    check_output("spur_fifo_unchanged", 32'(rd_outstanding_o), 32'd0);
    tick();
    settle();
    check_output("spur_pulse_end", 32'(spurious_resp_o), 32'd0);

    // Round robin: all four write continuously, memory always accepts.
    for (int i = 0; i < 4; i++) begin
      set_master(i, 1'b1, 1'b1, 32'h10 * (i + 1));
      ack_cnt[i] = 0;
    end
    s_if.ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      exp_v = 4'b0001 << (k % 4);
      check_output($sformatf("rr_ack_%0d", k), 32'(ack_vec), 32'(exp_v));
      check_output($sformatf("rr_addr_%0d", k), s_if.addr, 32'h10 * ((k % 4) + 1));
      if (k < 4) for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack_vec[i]);
      tick();
    end
    for (int i = 0; i < 4; i++) check_output($sformatf("rr_ack_count_m%0d", i), 32'(ack_cnt[i]), 32'd1);
    for (int i = 0; i < 4; i++) set_master(i, 1'b0, 1'b0, 32'h0);

    // Pipelined reads: m2 then m0, responses come back in order.
    set_master(2, 1'b1, 1'b0, 32'h100);
    settle();
    check_output("pr_m2_ack", 32'(m2_if.ack), 32'd1);
    check_output("pr_s_addr_m2", s_if.addr, 32'h100);
    check_output("pr_s_we", 32'(s_if.we), 32'd0);
    tick();
    set_master(2, 1'b0, 1'b0, 32'h0);
    set_master(0, 1'b1, 1'b0, 32'h200);
    settle();
    check_output("pr_outstanding_1", 32'(rd_outstanding_o), 32'd1);
    check_output("pr_m0_ack", 32'(m0_if.ack), 32'd1);
    check_output("pr_s_addr_m0", s_if.addr, 32'h200);
    tick();
    set_master(0, 1'b0, 1'b0, 32'h0);
    s_if.resp = 1'b1; s_if.rdata = 32'hAAAA;
    settle();
    check_output("pr_outstanding_2", 32'(rd_outstanding_o), 32'd2);
    check_output("pr_resp_vec_1", 32'(resp_vec), 32'b0100);
    check_output("pr_m2_rdata", m2_if.rdata, 32'hAAAA);
    check_output("pr_m0_rdata_zero", m0_if.rdata, 32'h0);
    tick();
    s_if.rdata = 32'hBBBB;
    settle();
    check_output("pr_outstanding_3", 32'(rd_outstanding_o), 32'd1);
    check_output("pr_resp_vec_2", 32'(resp_vec), 32'b0001);
    check_output("pr_m0_rdata", m0_if.rdata, 32'hBBBB);
    tick();
    s_if.resp = 1'b0; s_if.rdata = 32'h0;
    settle();
    check_output("pr_outstanding_4", 32'(rd_outstanding_o), 32'd0);

    // Fill the owner FIFO with four reads from m0.
    set_master(0, 1'b1, 1'b0, 32'h300);
    for (int k = 0; k < 4; k++) tick();
    set_master(0, 1'b0, 1'b0, 32'h0);
    settle();
    check_output("full_outstanding", 32'(rd_outstanding_o), 32'd4);
    set_master(1, 1'b1, 1'b0, 32'h111);
    set_master(3, 1'b1, 1'b1, 32'h333);
    settle();
    check_output("full_ack_vec_m3", 32'(ack_vec), 32'b1000);
    check_output("full_s_addr_m3", s_if.addr, 32'h333);
    tick();
    set_master(3, 1'b0, 1'b0, 32'h0);
    settle();
    check_output("full_m1_blocked", 32'(m1_if.ack), 32'd0);
    check_output("full_idle_s_req", 32'(s_if.req), 32'd0);
    check_output("full_idle_s_addr", s_if.addr, 32'h0);
    s_if.resp = 1'b1; s_if.rdata = 32'h5555;
    settle();
    check_output("full_m1_blocked_pop", 32'(m1_if.ack), 32'd0);
    check_output("full_pop_m0", 32'(resp_vec), 32'b0001);
    tick();
    s_if.resp = 1'b0;
    settle();
    check_output("full_m1_accepted", 32'(m1_if.ack), 32'd1);
    check_output("full_s_addr_m1", s_if.addr, 32'h111);
    tick();
    set_master(1, 1'b0, 1'b0, 32'h0);
    owners = '{0, 0, 0, 1};
    s_if.resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_if.rdata = 32'hC000 + 32'(k);
      settle();
      exp_v = 4'b0001 << owners[k];
      check_output($sformatf("drain_resp_%0d", k), 32'(resp_vec), 32'(exp_v));
      tick();
    end
    s_if.resp = 1'b0;
    settle();
    check_output("drain_outstanding", 32'(rd_outstanding_o), 32'd0);

    // Grant hold while the memory stalls; rr_ptr is 2 so m0 would win unlocked.
    s_if.ack = 1'b0;
    set_master(1, 1'b1, 1'b0, 32'h404);
    settle();
    check_output("hold_s_addr_0", s_if.addr, 32'h404);
    tick();
    set_master(0, 1'b1, 1'b1, 32'h500);
    for (int k = 1; k < 3; k++) begin
      settle();
      check_output($sformatf("hold_s_addr_%0d", k), s_if.addr, 32'h404);
      check_output($sformatf("hold_no_ack_%0d", k), 32'(ack_vec), 32'd0);
      tick();
    end
    s_if.ack = 1'b1;
    settle();
    check_output("hold_m1_ack", 32'(ack_vec), 32'b0010);
    check_output("hold_s_addr_ack", s_if.addr, 32'h404);
    tick();
    set_master(1, 1'b0, 1'b0, 32'h0);
    settle();
    check_output("hold_m0_write_ack", 32'(ack_vec), 32'b0001);
    check_output("write_with_read_out", 32'(rd_outstanding_o), 32'd1);
    tick();
    set_master(0, 1'b1, 1'b0, 32'h600);
    tick();
    set_master(0, 1'b0, 1'b0, 32'h0);
    settle();
    check_output("rst_pre_outstanding", 32'(rd_outstanding_o), 32'd2);

    // Reset with two reads outstanding discards their ownership.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check_output("rst_outstanding", 32'(rd_outstanding_o), 32'd0);
    s_if.resp = 1'b1; s_if.rdata = 32'h7777;
    settle();
    check_output("rst_resp_dropped", 32'(resp_vec), 32'd0);
    tick();
    s_if.resp = 1'b0;
    settle();
    check_output("rst_resp_spurious", 32'(spurious_resp_o), 32'd1);
    tick();
    settle();
    check_output("rst_spurious_end", 32'(spurious_resp_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
